cmd_frame_fifo: RTL and testbench
=================================

Name: cmd_frame_fifo

Overview:
- Single-clock, parametrised command FIFO between the host byte interface and the DDS controller's command reader; next generation of the fixed byte FIFO feeding the controller's mem_out/mem_rclk path.
- Stores variable-length frames: a header word, then the payload words whose count is given in the header's low LEN_BITS bits.
- Frames become visible to the reader only after their last word is written. Partial frames are rolled back on overflow, so the controller never sees a truncated command.

Parameters:
- DW, 8, data word width
- AW, 5, address width; depth = 2**AW words
- LEN_BITS, 4, header bits [LEN_BITS-1:0] = payload word count (0..2**LEN_BITS-1); require LEN_BITS <= DW
- TIMEOUT, 1000, idle cycles before a partial frame is abandoned (used only with FRAME_TIMEOUT_EN)

Ports:
- clk  in  1  system clock; all logic on posedge
- rst  in  1  synchronous, active-high reset
- clear  in  1  synchronous flush; same effect as rst on all state and flags
- wr_en  in  1  write strobe; one word per cycle while high
- wr_data  in  DW  write word
- wr_ready  out  1  high when physical storage is not full
- rd_en  in  1  pop head word; ignored when rd_valid=0
- rd_data  out  DW  head word, first-word-fall-through
- rd_valid  out  1  at least one committed word is present
- rd_sof  out  1  head word is a frame header
- rd_eof  out  1  head word is the last word of its frame
- frame_avail  out  1  frame_cnt != 0
- frame_cnt  out  AW+1  number of complete frames not yet fully read
- level  out  AW+1  committed words stored
- overflow  out  1  sticky: a frame was dropped for lack of space
- timeout  out  1  sticky: a partial frame was abandoned (FRAME_TIMEOUT_EN only, else 0)

Behaviour:
- Reset/clear: all pointers and counters 0; rd_valid=0, wr_ready=1, frame_avail=0, overflow=0, timeout=0; write FSM -> W_HDR; read FSM -> R_HDR. rst or clear in the middle of a frame discards it without setting any flag.
- Pointers:
  - wr_ptr (speculative) and wr_commit, each AW+1 bits with a wrap bit; rd_ptr likewise.
  - physical full = (wr_ptr - rd_ptr) == 2**AW.
  - level = wr_commit - rd_ptr, modulo 2**(AW+1).
- Write FSM:
  - W_HDR: an accepted word is stored at wr_ptr and wr_ptr advances. The write remain counter is loaded with header[LEN_BITS-1:0]. If that value is 0, commit this cycle and stay in W_HDR; otherwise go to W_BODY.
  - W_BODY: each accepted word decrements remain. When the final word is accepted, set wr_commit <= wr_ptr+1, frame_cnt +1, and return to W_HDR.
  - Commit is registered: rd_valid/level reflect the new frame one cycle after the last word is written.
  - Write while full, in either state: roll wr_ptr back to wr_commit and set overflow. Remaining words of that frame are still counted but discarded in W_DROP; return to W_HDR after the frame's last word. A write while full in W_HDR drops that header and enters W_DROP with remain taken from the dropped header.
- Read FSM:
  - R_HDR: rd_sof=1. Pop loads the read remain counter from rd_data[LEN_BITS-1:0]; go to R_BODY if nonzero.
  - rd_eof=1 when the head word is a zero-length header, or when read remain == 1 in R_BODY.
  - A pop with rd_eof=1 decrements frame_cnt and returns to R_HDR.
- Simultaneous commit and final pop in one cycle: frame_cnt unchanged (+1 -1); level = old + committed words - 1.
- rd_sof/rd_eof are valid only while rd_valid=1; otherwise 0.
- A frame longer than free space can never commit; it always overflows. Host must keep frame length <= 2**AW.

Optional Feature:
- FRAME_TIMEOUT_EN defined:
  - Idle counter runs while the write FSM is in W_BODY with wr_en low; any accepted word resets it.
  - When the counter reaches TIMEOUT: roll back to wr_commit, set timeout sticky, go to W_HDR.
- FRAME_TIMEOUT_EN undefined: no counter; timeout tied 0; a partial frame waits indefinitely.

Test Plan:
- Write 0x43,0x00,0xC8,0x11 on consecutive cycles -> rd_valid rises one cycle after the 0x11 write; level=4, frame_cnt=1. Pop 4 words -> rd_sof on 0x43 only, rd_eof on 0x11 only; frame_cnt=0.
- Write header 0x40 (zero length) -> commits alone; rd_sof=rd_eof=1; one pop empties the FIFO.
- AW=3: write frame 0x47+7 bytes (8 words) -> full, wr_ready=0. Next frame 0x42,0xAA,0xBB -> overflow=1; level stays 8; first frame reads back intact.
- Write first frame's last word in the same cycle as popping a prior frame's eof word -> frame_cnt unchanged; level correct; no lost words.
- Assert rst midway through writing 0x45 + 2 of 5 bytes -> all outputs return to reset values next cycle; overflow=0.
- FRAME_TIMEOUT_EN, TIMEOUT=20: write 0x43,0x01 then idle 20 cycles -> timeout=1, level=0. A following complete frame is accepted normally.

Source files
------------

// File: rtl/cmd_frame_fifo.sv
// Single-clock command FIFO that holds whole frames (header + payload). Frames become readable only once complete.
// Optional idle-timeout abandonment of partial frames is enabled with `define FRAME_TIMEOUT_EN.
module cmd_frame_fifo #(
    parameter int DW       = 8,
    parameter int AW       = 5,
    parameter int LEN_BITS = 4,
    parameter int TIMEOUT  = 1000
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          wr_en,
    input  logic [DW-1:0] wr_data,
    output logic          wr_ready,
    input  logic          rd_en,
    output logic [DW-1:0] rd_data,
    output logic          rd_valid,
    output logic          rd_sof,
    output logic          rd_eof,
    output logic          frame_avail,
    output logic [AW:0]   frame_cnt,
    output logic [AW:0]   level,
    output logic          overflow,
    output logic          timeout
);

    localparam int DEPTH = 2**AW;

    typedef enum logic [1:0] {W_HDR, W_BODY, W_DROP} w_state_t;
    typedef enum logic       {R_HDR, R_BODY}         r_state_t;

    logic [DW-1:0]       mem [DEPTH];
    logic [AW:0]         wr_ptr, wr_commit, rd_ptr;
    logic [LEN_BITS-1:0] w_remain, r_remain;
    w_state_t            w_state;
    r_state_t            r_state;

    logic                full, pop, commit, frame_done, idle_expire;
    logic [LEN_BITS-1:0] wr_len, rd_len;

    assign wr_len      = wr_data[LEN_BITS-1:0];
    assign rd_len      = rd_data[LEN_BITS-1:0];
    assign full        = (wr_ptr - rd_ptr) == (AW+1)'(DEPTH);
    assign wr_ready    = !full;
    assign level       = wr_commit - rd_ptr;
    assign rd_valid    = level != '0;
    assign rd_data     = mem[rd_ptr[AW-1:0]];
    assign rd_sof      = rd_valid && (r_state == R_HDR);
    assign rd_eof      = rd_valid && (((r_state == R_HDR) && (rd_len == '0)) ||
                                      ((r_state == R_BODY) && (r_remain == LEN_BITS'(1))));
    assign pop         = rd_en && rd_valid;
    assign frame_done  = pop && rd_eof;
    assign commit      = wr_en && !full &&
                         (((w_state == W_HDR) && (wr_len == '0)) ||
                          ((w_state == W_BODY) && (w_remain == LEN_BITS'(1))));
    assign frame_avail = frame_cnt != '0;

`ifdef FRAME_TIMEOUT_EN
    localparam int IW = $clog2(TIMEOUT + 1);

    logic [IW-1:0] idle_cnt;
    logic          timeout_q;

    assign idle_expire = (w_state == W_BODY) && !wr_en && (idle_cnt == IW'(TIMEOUT - 1));
    assign timeout     = timeout_q;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            idle_cnt  <= '0;
            timeout_q <= 1'b0;
        end else begin
            if ((w_state == W_BODY) && !wr_en && !idle_expire)
                idle_cnt <= idle_cnt + IW'(1);
            else
                idle_cnt <= '0;
            if (idle_expire)
                timeout_q <= 1'b1;
        end
    end
`else
    assign idle_expire = 1'b0;
    assign timeout     = 1'b0;
`endif

    // NOTE: storage carries no reset; pointers alone define which words are meaningful.
    always_ff @(posedge clk) begin
        if (wr_en && !full && ((w_state == W_HDR) || (w_state == W_BODY)))
            mem[wr_ptr[AW-1:0]] <= wr_data;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            wr_ptr    <= '0;
            wr_commit <= '0;
            w_remain  <= '0;
            w_state   <= W_HDR;
            overflow  <= 1'b0;
        end else if (idle_expire) begin
            wr_ptr  <= wr_commit;
            w_state <= W_HDR;
        end else if (wr_en) begin
            case (w_state)
                W_HDR: begin
                    w_remain <= wr_len;
                    if (full) begin
                        wr_ptr   <= wr_commit;
                        overflow <= 1'b1;
                        w_state  <= (wr_len == '0) ? W_HDR : W_DROP;
                    end else begin
                        wr_ptr <= wr_ptr + (AW+1)'(1);
                        if (wr_len == '0)
                            wr_commit <= wr_ptr + (AW+1)'(1);
                        else
                            w_state <= W_BODY;
                    end
                end
                W_BODY: begin
                    w_remain <= w_remain - LEN_BITS'(1);
                    if (full) begin
                        // The whole partial frame is discarded, not just this word.
                        wr_ptr   <= wr_commit;
                        overflow <= 1'b1;
                        w_state  <= (w_remain == LEN_BITS'(1)) ? W_HDR : W_DROP;
                    end else begin
                        wr_ptr <= wr_ptr + (AW+1)'(1);
                        if (w_remain == LEN_BITS'(1)) begin
                            wr_commit <= wr_ptr + (AW+1)'(1);
                            w_state   <= W_HDR;
                        end
                    end
                end
                W_DROP: begin
                    w_remain <= w_remain - LEN_BITS'(1);
                    if (w_remain == LEN_BITS'(1))
                        w_state <= W_HDR;
                end
                default: w_state <= W_HDR;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            rd_ptr    <= '0;
            r_remain  <= '0;
            r_state   <= R_HDR;
            frame_cnt <= '0;
        end else begin
            frame_cnt <= frame_cnt + (AW+1)'(commit) - (AW+1)'(frame_done);
            if (pop) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
                case (r_state)
                    R_HDR: begin
                        r_remain <= rd_len;
                        if (rd_len != '0)
                            r_state <= R_BODY;
                    end
                    R_BODY: begin
                        r_remain <= r_remain - LEN_BITS'(1);
                        if (r_remain == LEN_BITS'(1))
                            r_state <= R_HDR;
                    end
                    default: r_state <= R_HDR;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_cmd_frame_fifo.sv
// Bench for cmd_frame_fifo (AW=3, TIMEOUT=20): directed frame scenarios plus random traffic against a queue-based frame model.
module tb_cmd_frame_fifo;

    localparam int DW      = 8;
    localparam int AW      = 3;
    localparam int LB      = 4;
    localparam int TMO     = 20;
    localparam int DEPTH   = 2**AW;

    logic          clk = 1'b0;
    logic          rst, clear, wr_en, rd_en;
    logic [DW-1:0] wr_data, rd_data;
    logic          wr_ready, rd_valid, rd_sof, rd_eof, frame_avail, overflow, timeout;
    logic [AW:0]   frame_cnt, level;

    cmd_frame_fifo #(.DW(DW), .AW(AW), .LEN_BITS(LB), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .clear(clear),
        .wr_en(wr_en), .wr_data(wr_data), .wr_ready(wr_ready),
        .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid),
        .rd_sof(rd_sof), .rd_eof(rd_eof),
        .frame_avail(frame_avail), .frame_cnt(frame_cnt), .level(level),
        .overflow(overflow), .timeout(timeout)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: committed words carry frame-boundary flags decided when the frame completes.
    typedef struct packed {
        logic [DW-1:0] data;
        logic          sof;
        logic          eof;
    } entry_t;

    entry_t        q[$];
    logic [DW-1:0] pq[$];
    int            need;
    bit            dropping, m_ovf, m_tmo;
    int            idle;

    function automatic void model_reset();
        q.delete();
        pq.delete();
        need = 0; dropping = 0; m_ovf = 0; m_tmo = 0; idle = 0;
    endfunction

    function automatic void model_commit();
        foreach (pq[i]) q.push_back('{pq[i], i == 0, i == pq.size() - 1});
        pq.delete();
    endfunction

    function automatic int model_fcnt();
        int n = 0;
        foreach (q[i]) if (q[i].eof) n++;
        return n;
    endfunction

    function automatic void model_step(input logic we, input logic [DW-1:0] wd, input logic re);
        bit full_m;
        int len;
        if (rst || clear) begin
            model_reset();
            return;
        end
        full_m = (q.size() + pq.size()) == DEPTH;
        if (re && q.size() != 0) void'(q.pop_front());
`ifdef FRAME_TIMEOUT_EN
        if (need > 0 && !dropping && !we) begin
            idle++;
            if (idle == TMO) begin
                pq.delete();
                need  = 0;
                m_tmo = 1;
                idle  = 0;
            end
        end else begin
            idle = 0;
        end
`endif
        if (we) begin
            if (need == 0) begin
                len  = int'(wd[LB-1:0]);
                need = len;
                if (full_m) begin
                    m_ovf    = 1;
                    dropping = (len != 0);
                end else begin
                    pq.push_back(wd);
                    if (len == 0) model_commit();
                end
            end else begin
                need--;
                if (dropping) begin
                    if (need == 0) dropping = 0;
                end else if (full_m) begin
                    m_ovf = 1;
                    pq.delete();
                    dropping = (need != 0);
                end else begin
                    pq.push_back(wd);
                    if (need == 0) model_commit();
                end
            end
        end
    endfunction

    task automatic compare_all();
        int fc;
        bit ev;
        fc = model_fcnt();
        ev = q.size() != 0;
        check("rd_valid",    32'(rd_valid),    32'(ev));
        check("level",       32'(level),       32'(q.size()));
        check("frame_cnt",   32'(frame_cnt),   32'(fc));
        check("frame_avail", 32'(frame_avail), 32'(fc != 0));
        check("wr_ready",    32'(wr_ready),    32'((q.size() + pq.size()) != DEPTH));
        check("overflow",    32'(overflow),    32'(m_ovf));
        check("timeout",     32'(timeout),     32'(m_tmo));
        if (ev) begin
            check("rd_data", 32'(rd_data), 32'(q[0].data));
            check("rd_sof",  32'(rd_sof),  32'(q[0].sof));
            check("rd_eof",  32'(rd_eof),  32'(q[0].eof));
        end else begin
            check("rd_sof_idle", 32'(rd_sof), 32'(0));
            check("rd_eof_idle", 32'(rd_eof), 32'(0));
        end
    endtask

    // Inputs change on the falling edge; outputs are compared on the next falling edge.
    task automatic step(input logic we, input logic [DW-1:0] wd, input logic re);
        wr_en   = we;
        wr_data = wd;
        rd_en   = re;
        model_step(we, wd, re);
        @(posedge clk);
        @(negedge clk);
        compare_all();
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, 1'b1);
    endtask

    initial begin
        int gen_left;
        logic          we, re;
        logic [DW-1:0] wd;
        int            len;

        rst = 1'b1; clear = 1'b0; wr_en = 1'b0; rd_en = 1'b0; wr_data = '0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        compare_all();
        check("rst_wr_ready", 32'(wr_ready), 32'(1));
        check("rst_level",    32'(level),    32'(0));

        // Four-word frame
        step(1'b1, 8'h43, 1'b0);
        step(1'b1, 8'h00, 1'b0);
        step(1'b1, 8'hC8, 1'b0);
        check("t1_not_yet", 32'(rd_valid), 32'(0));
        step(1'b1, 8'h11, 1'b0);
        check("t1_valid",  32'(rd_valid),  32'(1));
        check("t1_level",  32'(level),     32'(4));
        check("t1_fcnt",   32'(frame_cnt), 32'(1));
        check("t1_sof",    32'(rd_sof),    32'(1));
        check("t1_hdr",    32'(rd_data),   32'h43);
        drain(3);
        check("t1_last",     32'(rd_data), 32'h11);
        check("t1_last_eof", 32'(rd_eof),  32'(1));
        check("t1_last_sof", 32'(rd_sof),  32'(0));
        drain(1);
        check("t1_fcnt_end", 32'(frame_cnt), 32'(0));

        // Zero-length header
        step(1'b1, 8'h40, 1'b0);
        check("t2_sof", 32'(rd_sof), 32'(1));
        check("t2_eof", 32'(rd_eof), 32'(1));
        drain(1);
        check("t2_empty", 32'(rd_valid), 32'(0));

        // Fill to full, then overflow a second frame
        step(1'b1, 8'h47, 1'b0);
        for (int i = 1; i <= 7; i++) step(1'b1, 8'(i * 16 + i), 1'b0);
        check("t3_full",  32'(wr_ready), 32'(0));
        check("t3_level", 32'(level),    32'(8));
        step(1'b1, 8'h42, 1'b0);
        step(1'b1, 8'hAA, 1'b0);
        step(1'b1, 8'hBB, 1'b0);
        check("t3_ovf",       32'(overflow), 32'(1));
        check("t3_level_ovf", 32'(level),    32'(8));
        check("t3_head",      32'(rd_data),  32'h47);
        drain(8);
        check("t3_drained", 32'(frame_cnt), 32'(0));

        // Commit and final pop of the previous frame in the same cycle
        step(1'b1, 8'h41, 1'b0);
        step(1'b1, 8'h55, 1'b0);
        step(1'b1, 8'h42, 1'b1);
        step(1'b1, 8'h66, 1'b0);
        check("t4_fcnt_pre", 32'(frame_cnt), 32'(1));
        step(1'b1, 8'h77, 1'b1);
        check("t4_fcnt",  32'(frame_cnt), 32'(1));
        check("t4_level", 32'(level),     32'(3));
        check("t4_head",  32'(rd_data),   32'h42);
        drain(3);

        // Reset in the middle of a frame
        step(1'b1, 8'h45, 1'b0);
        step(1'b1, 8'h01, 1'b0);
        step(1'b1, 8'h02, 1'b0);
        rst = 1'b1;
        step(1'b0, '0, 1'b0);
        rst = 1'b0;
        check("t5_ovf",      32'(overflow),  32'(0));
        check("t5_level",    32'(level),     32'(0));
        check("t5_valid",    32'(rd_valid),  32'(0));
        check("t5_wr_ready", 32'(wr_ready),  32'(1));
        check("t5_fcnt",     32'(frame_cnt), 32'(0));
        step(1'b1, 8'h40, 1'b0);
        check("t5_fresh_hdr", 32'(rd_eof), 32'(1));
        drain(1);

`ifdef FRAME_TIMEOUT_EN
        step(1'b1, 8'h43, 1'b0);
        step(1'b1, 8'h01, 1'b0);
        repeat (TMO - 1) step(1'b0, '0, 1'b0);
        check("t6_early", 32'(timeout), 32'(0));
        step(1'b0, '0, 1'b0);
        check("t6_tmo",   32'(timeout), 32'(1));
        check("t6_level", 32'(level),   32'(0));
        step(1'b1, 8'h41, 1'b0);
        step(1'b1, 8'h99, 1'b0);
        check("t6_after_level", 32'(level),     32'(2));
        check("t6_after_fcnt",  32'(frame_cnt), 32'(1));
        drain(2);
`endif

        // Random traffic
        gen_left = 0;
        for (int c = 0; c < 4000; c++) begin
            clear = ($urandom_range(0, 199) == 0);
            we    = ($urandom_range(0, 9) < 7);
            re    = ($urandom_range(0, 9) < 6);
            wd    = 8'($urandom);
            if (we) begin
                if (gen_left == 0) begin
                    len = ($urandom_range(0, 15) == 0) ? 9 : int'($urandom_range(0, 5));
                    wd  = {4'($urandom_range(0, 15)), 4'(len)};
                    gen_left = len;
                end else begin
                    gen_left--;
                end
            end
            if (clear) gen_left = 0;
            step(we, wd, re);
        end
        clear = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
